// File: rtl/cluster_clock_switch_ctrl.sv
// ---------------------------------------------------------------------------
// cluster_clock_switch_ctrl
//
// Sequencer for the cluster 2:1 clock mux. A switch request arrives on a
// valid/ready handshake. For a real select change the downstream clock gate
// is closed, held closed for GATE_WAIT cycles, the mux select is flipped,
// and after SETTLE_WAIT more cycles the gate is reopened. A request for the
// select that is already active completes in one cycle without touching the
// gate. The block runs entirely on the free-running reference clock, which
// never passes through the mux it controls.
//
// Ports:
//   clk_i        free-running reference clock
//   rst_i        synchronous active-high reset
//   req_valid_i  switch request valid
//   req_sel_i    requested select (0 = clk0, 1 = clk1)
//   req_ready_o  request can be accepted (IDLE only)
//   clk_sel_o    registered mux select
//   clk_en_o     registered clock-gate enable
//   busy_o       switch sequence in progress
//   done_o       one-cycle pulse when a request completes
// ---------------------------------------------------------------------------
module cluster_clock_switch_ctrl #(
  parameter int unsigned GATE_WAIT   = 4,
  parameter int unsigned SETTLE_WAIT = 4,
  parameter logic        RST_SEL     = 1'b0,
  parameter int unsigned CNT_W       =
    $clog2(((GATE_WAIT > SETTLE_WAIT) ? GATE_WAIT : SETTLE_WAIT) + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_valid_i,
  input  logic req_sel_i,
  output logic req_ready_o,
  output logic clk_sel_o,
  output logic clk_en_o,
  output logic busy_o,
  output logic done_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE_OFF = 2'd1,
    SWITCH   = 2'd2,
    NOP_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_WAIT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_WAIT - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             reqSel_q;
  logic             clkSel_q;
  logic             clkEn_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  // Every output is a flop so the mux select and gate enable can never
  // glitch. ready/busy are updated on the same edges as the state so they
  // always agree with it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reqSel_q <= RST_SEL;
      clkSel_q <= RST_SEL;
      clkEn_q  <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i && ready_q) begin
            reqSel_q <= req_sel_i;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            if (req_sel_i != clkSel_q) begin
              // Close the gate first; the select only moves once the
              // quiet time has elapsed.
              clkEn_q <= 1'b0;
              cnt_q   <= GATE_LOAD;
              state_q <= GATE_OFF;
            end else begin
              state_q <= NOP_DONE;
            end
          end
        end
        GATE_OFF: begin
          if (cnt_q == '0) begin
            clkSel_q <= reqSel_q;
            cnt_q    <= SETTLE_LOAD;
            state_q  <= SWITCH;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        SWITCH: begin
          if (cnt_q == '0) begin
            clkEn_q <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        NOP_DONE: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          clkEn_q <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign clk_sel_o   = clkSel_q;
  assign clk_en_o    = clkEn_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
